// File: rtl/stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// stream_demux_1to2
//
// Purpose:
//   Routes one valid/ready input stream into two independent output channels
//   (A and B). Each accepted word goes to the channel picked either by in_sel
//   (AUTO=0) or by an internal toggle that alternates A,B,A,... on every
//   accepted word (AUTO=1, de-interleave). Each channel buffers its words in
//   its own small FIFO, so a stalled consumer only blocks words aimed at it.
//
// Parameters:
//   WIDTH  data width in bits
//   DEPTH  per-channel FIFO depth (power of 2, >= 2)
//   AUTO   0: route by in_sel, 1: route by internal toggle (in_sel ignored)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_data word, in_sel target (0=A, 1=B)
//   a_valid/a_ready       channel A handshake; a_data head word, a_count occupancy
//   b_valid/b_ready       channel B handshake; b_data head word, b_count occupancy
// -----------------------------------------------------------------------------
module stream_demux_1to2 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int AUTO  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [WIDTH-1:0]           a_data,
    output logic [$clog2(DEPTH):0]     a_count,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [WIDTH-1:0]           b_data,
    output logic [$clog2(DEPTH):0]     b_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Channel index 0 = A, 1 = B.
    logic [1:0]       valid_w;
    logic [1:0]       ready_w;
    logic [WIDTH-1:0] data_w  [2];
    logic [CW-1:0]    count_w [2];

    logic toggle_q, toggle_d;
    logic tgt;
    logic accept;
    logic [1:0] push_sel;

    assign ready_w = {b_ready, a_ready};

    assign tgt = (AUTO != 0) ? toggle_q : in_sel;

    // A full target blocks the push even if it pops this cycle: no pass-through.
    assign in_ready = rst_n & (count_w[tgt] != CW'(DEPTH));
    assign accept   = in_valid & in_ready;
    assign push_sel = {tgt, ~tgt};

    // Toggle only advances on an accepted word, so a stalled B-bound word
    // keeps targeting B until it gets in.
    always_comb begin
        toggle_d = toggle_q;
        if (AUTO != 0) begin
            toggle_d = toggle_q ^ accept;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_ch
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
            logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]    count_q, count_d;
            logic             push, pop, valid;

            assign valid = (count_q != '0);
            assign push  = accept & push_sel[gi];
            assign pop   = valid & ready_w[gi];

            // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
                if (push && !pop) begin
                    count_d = count_q + CW'(1);
                end else if (!push && pop) begin
                    count_d = count_q - CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Storage is never cleared; reset only empties the pointers.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_data;
                end
            end

            assign valid_w[gi] = valid;
            assign data_w[gi]  = valid ? mem_q[rd_ptr_q] : '0;
            assign count_w[gi] = count_q;
        end
    endgenerate

    assign a_valid = valid_w[0];
    assign a_data  = data_w[0];
    assign a_count = count_w[0];
    assign b_valid = valid_w[1];
    assign b_data  = data_w[1];
    assign b_count = count_w[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1to2
//
// Two instances share clock and reset: index 0 routes by in_sel (AUTO=0),
// index 1 de-interleaves (AUTO=1). A queue-per-channel reference model
// predicts every output before each rising edge.
// -----------------------------------------------------------------------------
module tb_stream_demux_1to2;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid [2];
    logic             in_ready [2];
    logic [WIDTH-1:0] in_data  [2];
    logic             in_sel   [2];
    logic             a_valid  [2];
    logic             a_ready  [2];
    logic [WIDTH-1:0] a_data   [2];
    logic [CW-1:0]    a_count  [2];
    logic             b_valid  [2];
    logic             b_ready  [2];
    logic [WIDTH-1:0] b_data   [2];
    logic [CW-1:0]    b_count  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_dut
            stream_demux_1to2 #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AUTO  (gi)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (in_valid[gi]),
                .in_ready (in_ready[gi]),
                .in_data  (in_data[gi]),
                .in_sel   (in_sel[gi]),
                .a_valid  (a_valid[gi]),
                .a_ready  (a_ready[gi]),
                .a_data   (a_data[gi]),
                .a_count  (a_count[gi]),
                .b_valid  (b_valid[gi]),
                .b_ready  (b_ready[gi]),
                .b_data   (b_data[gi]),
                .b_count  (b_count[gi])
            );
        end
    endgenerate

    // Reference model: queue index = dut*2 + channel (0=A, 1=B).
    logic [WIDTH-1:0] mq [4][$];
    bit               mtog  [2];
    bit               stall [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        for (int d = 0; d < 2; d++) begin
            mtog[d]  = 1'b0;
            stall[d] = 1'b0;
        end
    endtask

    // Compare all outputs just before the rising edge, then advance the model
    // by the handshakes that edge will complete.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int  qa = d * 2;
            int  qb = d * 2 + 1;
            bit  tgt;
            bit  er;
            bit  pa;
            bit  pb;
            tgt = (d == 1) ? mtog[d] : in_sel[d];
            er  = rst_n && (mq[qa + int'(tgt)].size() != DEPTH);
            chk($sformatf("d%0d in_ready", d), 32'(in_ready[d]), 32'(er));
            chk($sformatf("d%0d a_valid", d),  32'(a_valid[d]),  32'(mq[qa].size() != 0));
            chk($sformatf("d%0d a_data", d),   32'(a_data[d]),   mq[qa].size() != 0 ? 32'(mq[qa][0]) : 32'd0);
            chk($sformatf("d%0d a_count", d),  32'(a_count[d]),  32'(mq[qa].size()));
            chk($sformatf("d%0d b_valid", d),  32'(b_valid[d]),  32'(mq[qb].size() != 0));
            chk($sformatf("d%0d b_data", d),   32'(b_data[d]),   mq[qb].size() != 0 ? 32'(mq[qb][0]) : 32'd0);
            chk($sformatf("d%0d b_count", d),  32'(b_count[d]),  32'(mq[qb].size()));

            pa = rst_n && (mq[qa].size() != 0) && a_ready[d];
            pb = rst_n && (mq[qb].size() != 0) && b_ready[d];
            if (pa) $display("t=%0t dut%0d pop  A %02h", $time, d, mq[qa].pop_front());
            if (pb) $display("t=%0t dut%0d pop  B %02h", $time, d, mq[qb].pop_front());
            stall[d] = in_valid[d] && !er && rst_n;
            if (in_valid[d] && er) begin
                mq[qa + int'(tgt)].push_back(in_data[d]);
                $display("t=%0t dut%0d push %02h -> %s", $time, d, in_data[d], tgt ? "B" : "A");
                if (d == 1) mtog[d] = ~mtog[d];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_data[d]  = '0;
            in_sel[d]   = 1'b0;
            a_ready[d]  = 1'b1;
            b_ready[d]  = 1'b1;
        end
    endtask

    // Drive one instance for one cycle; the other idles with both readies high.
    task automatic step(input int d, input bit v, input bit sel, input logic [7:0] data,
                        input bit ar, input bit br);
        idle_all();
        in_valid[d] = v;
        in_sel[d]   = sel;
        in_data[d]  = data;
        a_ready[d]  = ar;
        b_ready[d]  = br;
        cycle();
    endtask

    initial begin
        idle_all();
        model_reset();

        // Reset state, with a word offered: nothing may be accepted.
        in_valid[0] = 1'b1;
        in_valid[1] = 1'b1;
        cycle();
        cycle();
        idle_all();
        rst_n = 1'b1;
        cycle();

        // Manual routing: 0x11 to A, 0x22 to B, then drain.
        step(0, 1, 0, 8'h11, 1, 1);
        step(0, 1, 1, 8'h22, 1, 1);
        repeat (3) step(0, 0, 0, 8'h00, 1, 1);

        // A stalled: third A word blocked, B word still goes through, then drain.
        step(0, 1, 0, 8'h01, 0, 1);
        step(0, 1, 0, 8'h02, 0, 1);
        step(0, 1, 0, 8'h03, 0, 1);
        step(0, 1, 1, 8'h44, 0, 1);
        step(0, 1, 0, 8'h03, 1, 1);
        step(0, 1, 0, 8'h03, 1, 1);
        repeat (4) step(0, 0, 0, 8'h00, 1, 1);

        // Wrap: 01..08 into A with a_ready toggling every cycle.
        begin
            int k = 1;
            int guard = 0;
            bit ar = 1'b0;
            while (k <= 8 && guard < 64) begin
                step(0, 1, 0, 8'(k), ar, 1);
                if (!stall[0]) k++;
                ar = ~ar;
                guard++;
            end
            chk("wrap all accepted", 32'(k), 32'd9);
            repeat (4) step(0, 0, 0, 8'h00, 1, 1);
        end

        // Auto de-interleave with B blocked.
        step(1, 1, 0, 8'hA0, 1, 0);
        step(1, 1, 0, 8'hA1, 1, 0);
        step(1, 1, 0, 8'hA2, 1, 0);
        step(1, 1, 0, 8'hA3, 1, 0);
        step(1, 1, 0, 8'hA4, 1, 0);
        step(1, 1, 1, 8'hA5, 1, 0);
        step(1, 1, 1, 8'hA5, 1, 0);
        step(1, 1, 1, 8'hA5, 1, 1);
        repeat (4) step(1, 0, 0, 8'h00, 1, 1);

        // Same-cycle push and pop on A at a_count=1.
        step(0, 1, 0, 8'h5A, 0, 1);
        step(0, 1, 0, 8'h5B, 1, 1);
        step(0, 1, 0, 8'h5C, 1, 1);
        repeat (3) step(0, 0, 0, 8'h00, 1, 1);

        // Randomized traffic on both instances, honouring the hold rule.
        for (int n = 0; n < 300; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!stall[d]) begin
                    in_valid[d] = ($urandom_range(0, 9) < 7);
                    in_sel[d]   = 1'($urandom);
                    in_data[d]  = 8'($urandom);
                end
                a_ready[d] = ($urandom_range(0, 2) != 0);
                b_ready[d] = ($urandom_range(0, 2) != 0);
            end
            cycle();
        end

        // Mid-operation reset: fill A on both, then drop rst_n between edges.
        step(0, 1, 0, 8'hC1, 0, 1);
        step(0, 1, 0, 8'hC2, 0, 1);
        in_valid[1] = 1'b1;
        in_sel[1]   = 1'b0;
        in_data[1]  = 8'hD0;
        a_ready[1]  = 1'b0;
        b_ready[1]  = 1'b0;
        cycle();
        in_data[1]  = 8'hD1;
        cycle();
        in_data[1]  = 8'hD2;
        cycle();
        in_valid[0] = 1'b1;
        in_sel[0]   = 1'b0;
        a_ready[0]  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst d%0d a_valid", d),  32'(a_valid[d]),  32'd0);
            chk($sformatf("rst d%0d a_count", d),  32'(a_count[d]),  32'd0);
            chk($sformatf("rst d%0d in_ready", d), 32'(in_ready[d]), 32'd0);
            chk($sformatf("rst d%0d a_data", d),   32'(a_data[d]),   32'd0);
        end
        model_reset();
        cycle();
        rst_n = 1'b1;
        idle_all();
        step(1, 1, 0, 8'hE0, 1, 1);
        step(1, 1, 0, 8'hE1, 1, 1);
        repeat (3) step(1, 0, 0, 8'h00, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
